// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C WISHBONE sequencer: controller register map,
// CR/SR bit layout, response codes and the sequencer state enum.
package i2c_seq_pkg;

  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_RXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;
  localparam logic [2:0] ADR_SR     = 3'd4;

  localparam logic [7:0] CTR_EN  = 8'h80;
  localparam logic [7:0] CTR_IEN = 8'h40;

  localparam logic [7:0] CR_STA  = 8'h80;
  localparam logic [7:0] CR_STO  = 8'h40;
  localparam logic [7:0] CR_RD   = 8'h20;
  localparam logic [7:0] CR_WR   = 8'h10;
  localparam logic [7:0] CR_ACK  = 8'h08;
  localparam logic [7:0] CR_IACK = 8'h01;

  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;
  localparam int SR_IF    = 0;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_NACK = 2'd1,
    ERR_AL   = 2'd2,
    ERR_BUS  = 2'd3
  } rsp_err_e;

  typedef enum logic [3:0] {
    ST_INIT_PRL,
    ST_INIT_PRH,
    ST_INIT_CTR,
    ST_IDLE,
    ST_TXR,
    ST_CR,
    ST_WAIT,
    ST_READ_SR,
    ST_IACK,
    ST_EVAL,
    ST_STOP,
    ST_RXR,
    ST_DONE
  } seq_state_e;

  // Command for byte step 0..3; step 3 only occurs on reads (NACK'd data byte + STOP).
  function automatic logic [7:0] step_cr(input logic rw, input logic [1:0] step);
    case (step)
      2'd0:    return CR_STA | CR_WR;
      2'd1:    return CR_WR;
      2'd2:    return rw ? (CR_STA | CR_WR) : (CR_STO | CR_WR);
      default: return CR_RD | CR_ACK | CR_STO;
    endcase
  endfunction

endpackage

// File: rtl/i2c_wbm_access.sv
// Single WISHBONE master access: launches on start, holds the bus until ack,
// returns a done pulse with captured read data, or an err pulse on ack timeout.
module i2c_wbm_access #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       start,
  input  logic [2:0] adr,
  input  logic [7:0] wdat,
  input  logic       we,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic           stb_reg;
  logic           we_reg;
  logic           done_reg;
  logic           err_reg;
  logic [2:0]     adr_reg;
  logic [7:0]     dat_reg;
  logic [7:0]     rdata_reg;
  logic [TW-1:0]  tmr_reg;

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      stb_reg   <= 1'b0;
      we_reg    <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      rdata_reg <= '0;
      tmr_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (!stb_reg) begin
        if (start) begin
          stb_reg <= 1'b1;
          adr_reg <= adr;
          dat_reg <= wdat;
          we_reg  <= we;
          tmr_reg <= '0;
        end
      end else if (wbm_ack_i || tmr_reg == TW'(ACK_TIMEOUT - 1)) begin
        // Ack wins if it lands in the last allowed cycle.
        stb_reg  <= 1'b0;
        adr_reg  <= '0;
        dat_reg  <= '0;
        we_reg   <= 1'b0;
        done_reg <= wbm_ack_i;
        err_reg  <= !wbm_ack_i;
        if (wbm_ack_i) rdata_reg <= wbm_dat_i;
      end else begin
        tmr_reg <= tmr_reg + TW'(1);
      end
    end
  end

  assign busy      = stb_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign rdata     = rdata_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_stb_o = stb_reg;
  assign wbm_cyc_o = stb_reg;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Turns one host register read/write request into the I2C byte-controller access sequence.
// Build option: define I2C_SEQ_IRQ_EN to wait on wbm_inta_i instead of polling SR.TIP.
module i2c_wb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE    = 16'd99,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          POLL_GAP    = 4
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i,
  input  logic       wbm_inta_i
);

`ifdef I2C_SEQ_IRQ_EN
  localparam logic [7:0] CTR_VALUE = CTR_EN | CTR_IEN;
`else
  localparam logic [7:0] CTR_VALUE = CTR_EN;
`endif

  seq_state_e state_reg, state_next;
  rsp_err_e   err_reg, err_next;
  logic       rw_reg, rw_next;
  logic [6:0] dev_reg, dev_next;
  logic [7:0] ptr_reg, ptr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic [7:0] rdata_reg, rdata_next;
  logic [1:0] step_reg, step_next;
  logic       al_reg, al_next;
  logic       nack_reg, nack_next;
`ifndef I2C_SEQ_IRQ_EN
  logic [7:0] gap_reg, gap_next;
  logic       unused_inta;
  assign unused_inta = wbm_inta_i;
`endif

  logic       acc_req, acc_start, acc_we;
  logic       acc_busy, acc_done, acc_err;
  logic [2:0] acc_adr;
  logic [7:0] acc_wdat, acc_rdata;

  i2c_wbm_access #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_access (
    .wb_clk_i  (wb_clk_i),
    .arst_i    (arst_i),
    .start     (acc_start),
    .adr       (acc_adr),
    .wdat      (acc_wdat),
    .we        (acc_we),
    .busy      (acc_busy),
    .done      (acc_done),
    .err       (acc_err),
    .rdata     (acc_rdata),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_ack_i (wbm_ack_i)
  );

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    rw_next    = rw_reg;
    dev_next   = dev_reg;
    ptr_next   = ptr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    step_next  = step_reg;
    al_next    = al_reg;
    nack_next  = nack_reg;
`ifndef I2C_SEQ_IRQ_EN
    gap_next   = gap_reg;
`endif
    acc_req    = 1'b0;
    acc_adr    = '0;
    acc_wdat   = '0;
    acc_we     = 1'b0;

    case (state_reg)
      ST_INIT_PRL: begin
        acc_req = 1'b1; acc_adr = ADR_PRERLO; acc_wdat = PRESCALE[7:0]; acc_we = 1'b1;
        if (acc_done) state_next = ST_INIT_PRH;
      end
      ST_INIT_PRH: begin
        acc_req = 1'b1; acc_adr = ADR_PRERHI; acc_wdat = PRESCALE[15:8]; acc_we = 1'b1;
        if (acc_done) state_next = ST_INIT_CTR;
      end
      ST_INIT_CTR: begin
        acc_req = 1'b1; acc_adr = ADR_CTR; acc_wdat = CTR_VALUE; acc_we = 1'b1;
        if (acc_done) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          rw_next    = req_rw;
          dev_next   = req_dev;
          ptr_next   = req_reg;
          wdata_next = req_wdata;
          step_next  = 2'd0;
          rdata_next = '0;
          err_next   = ERR_OK;
          state_next = ST_TXR;
        end
      end
      ST_TXR: begin
        acc_req = 1'b1; acc_adr = ADR_TXR; acc_we = 1'b1;
        case (step_reg)
          2'd0:    acc_wdat = {dev_reg, 1'b0};
          2'd1:    acc_wdat = ptr_reg;
          default: acc_wdat = rw_reg ? {dev_reg, 1'b1} : wdata_reg;
        endcase
        if (acc_done) state_next = ST_CR;
      end
      ST_CR: begin
        acc_req = 1'b1; acc_adr = ADR_CR; acc_wdat = step_cr(rw_reg, step_reg); acc_we = 1'b1;
        if (acc_done) begin
          state_next = ST_WAIT;
`ifndef I2C_SEQ_IRQ_EN
          gap_next   = '0;
`endif
        end
      end
      ST_WAIT: begin
`ifdef I2C_SEQ_IRQ_EN
        if (wbm_inta_i) state_next = ST_READ_SR;
`else
        if (gap_reg == 8'(POLL_GAP - 1)) state_next = ST_READ_SR;
        else                             gap_next   = gap_reg + 8'd1;
`endif
      end
      ST_READ_SR: begin
        acc_req = 1'b1; acc_adr = ADR_SR;
        if (acc_done) begin
          al_next   = acc_rdata[SR_AL];
          nack_next = acc_rdata[SR_RXACK];
`ifdef I2C_SEQ_IRQ_EN
          state_next = ST_IACK;
`else
          if (acc_rdata[SR_TIP]) begin
            state_next = ST_WAIT;
            gap_next   = '0;
          end else begin
            state_next = ST_EVAL;
          end
`endif
        end
      end
      ST_IACK: begin
        acc_req = 1'b1; acc_adr = ADR_CR; acc_wdat = CR_IACK; acc_we = 1'b1;
        if (acc_done) state_next = ST_EVAL;
      end
      ST_EVAL: begin
        // Arbitration loss leaves the bus to the winner, so no STOP is issued.
        if (rw_reg && step_reg == 2'd3) begin
          state_next = ST_RXR;
        end else if (al_reg) begin
          err_next   = ERR_AL;
          state_next = ST_DONE;
        end else if (nack_reg) begin
          state_next = ST_STOP;
        end else if (!rw_reg && step_reg == 2'd2) begin
          state_next = ST_DONE;
        end else begin
          step_next  = step_reg + 2'd1;
          state_next = (rw_reg && step_reg == 2'd2) ? ST_CR : ST_TXR;
        end
      end
      ST_STOP: begin
        acc_req = 1'b1; acc_adr = ADR_CR; acc_wdat = CR_STO; acc_we = 1'b1;
        if (acc_done) begin
          err_next   = ERR_NACK;
          state_next = ST_DONE;
        end
      end
      ST_RXR: begin
        acc_req = 1'b1; acc_adr = ADR_RXR;
        if (acc_done) begin
          rdata_next = acc_rdata;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_INIT_PRL;
    endcase

    if (acc_err) begin
      if (state_reg == ST_INIT_PRL || state_reg == ST_INIT_PRH || state_reg == ST_INIT_CTR) begin
        state_next = ST_INIT_PRL;
      end else begin
        err_next   = ERR_BUS;
        state_next = ST_DONE;
      end
    end

    // Suppressed on the done/err cycle so the finished access is not relaunched.
    acc_start = acc_req && !acc_busy && !acc_done && !acc_err;
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_reg <= ST_INIT_PRL;
      err_reg   <= ERR_OK;
      rw_reg    <= 1'b0;
      dev_reg   <= '0;
      ptr_reg   <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      step_reg  <= '0;
      al_reg    <= 1'b0;
      nack_reg  <= 1'b0;
`ifndef I2C_SEQ_IRQ_EN
      gap_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      rw_reg    <= rw_next;
      dev_reg   <= dev_next;
      ptr_reg   <= ptr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      step_reg  <= step_next;
      al_reg    <= al_next;
      nack_reg  <= nack_next;
`ifndef I2C_SEQ_IRQ_EN
      gap_reg   <= gap_next;
`endif
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_DONE);
  assign rsp_rdata = rsp_valid ? rdata_reg : 8'h00;
  assign rsp_err   = rsp_valid ? err_reg : ERR_OK;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Directed bench for i2c_wb_sequencer (polling build) against a behavioural byte-controller slave.
module tb_i2c_wb_sequencer;

  logic       wb_clk_i = 1'b0;
  logic       arst_i = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i = '0;
  logic       wbm_we_o;
  logic       wbm_stb_o;
  logic       wbm_cyc_o;
  logic       wbm_ack_i = 1'b0;
  logic       wbm_inta_i = 1'b0;

  i2c_wb_sequencer dut (
    .wb_clk_i   (wb_clk_i),
    .arst_i     (arst_i),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_dev    (req_dev),
    .req_reg    (req_reg),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_we_o   (wbm_we_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_inta_i (wbm_inta_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Slave model: registered ack, logs writes as {adr,dat}, TIP=1 on the first SR poll after each CR write.
  logic        ack_en = 1'b1;
  logic [7:0]  sr_flags = 8'h00;
  logic [7:0]  rxr_val = 8'h00;
  int          tip_cnt = 0;
  logic [15:0] wlog[$];

  always @(posedge wb_clk_i) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && ack_en) begin
      wbm_ack_i <= 1'b1;
      if (wbm_we_o) begin
        wlog.push_back({5'd0, wbm_adr_o, wbm_dat_o});
        if (wbm_adr_o == 3'd4) tip_cnt <= 1;
      end else if (wbm_adr_o == 3'd4) begin
        wbm_dat_i <= sr_flags | ((tip_cnt > 0) ? 8'h02 : 8'h00);
        if (tip_cnt > 0) tip_cnt <= tip_cnt - 1;
      end else begin
        wbm_dat_i <= rxr_val;
      end
    end else begin
      wbm_ack_i <= 1'b0;
    end
  end

  int rsp_cnt = 0;
  int cyc_bad = 0;
  int stb_len = 0;
  int last_stb_len = 0;

  always @(negedge wb_clk_i) begin
    if (rsp_valid) rsp_cnt++;
    if (wbm_cyc_o !== wbm_stb_o) cyc_bad++;
    if (wbm_stb_o) begin
      stb_len++;
    end else begin
      if (stb_len != 0) last_stb_len = stb_len;
      stb_len = 0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_q[$];

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < wlog.size()) ? {16'h0, wlog[i]} : 32'hFFFF_FFFF, {16'h0, exp_q[i]});
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge wb_clk_i);
    while (!req_ready && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk(tag, req_ready, 1);
  endtask

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    @(negedge wb_clk_i);
    req_valid = 1'b1;
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = rg;
    req_wdata = wd;
    @(posedge wb_clk_i);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                        output logic [1:0] err, output logic [7:0] rd);
    int n;
    err = 2'bxx;
    rd  = 8'hxx;
    wait_ready("req_ready");
    send_req(rw, dev, rg, wd);
    n = 0;
    while (n < 3000) begin
      @(negedge wb_clk_i);
      if (rsp_valid) begin
        err = rsp_err;
        rd  = rsp_rdata;
        break;
      end
      n++;
    end
    if (n >= 3000) chk("rsp_wait", 0, 1);
    $display("req rw=%0d dev=%h reg=%h wdata=%h -> err=%0d rdata=%h wr_accesses=%0d",
             rw, dev, rg, wd, err, rd, wlog.size());
  endtask

  logic [1:0] e;
  logic [7:0] d;
  int         n_wait;
  int         rc;

  initial begin
    // Reset state
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_we", wbm_we_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    wlog.delete();
    arst_i = 1'b1;
    wait_ready("init_ready");
    exp_q = '{16'h0063, 16'h0100, 16'h0280};
    chk_log("init");

    // Register write, all ACK
    wlog.delete();
    sr_flags = 8'h00;
    do_req(1'b0, 7'h50, 8'h10, 8'hA5, e, d);
    exp_q = '{16'h03A0, 16'h0490, 16'h0310, 16'h0410, 16'h03A5, 16'h0450};
    chk_log("wr");
    chk("wr_err", e, 0);
    chk("wr_rdata", d, 0);

    // Register read with repeated start
    wlog.delete();
    rxr_val = 8'h3C;
    do_req(1'b1, 7'h50, 8'h02, 8'hFF, e, d);
    exp_q = '{16'h03A0, 16'h0490, 16'h0302, 16'h0410, 16'h03A1, 16'h0490, 16'h0468};
    chk_log("rd");
    chk("rd_err", e, 0);
    chk("rd_rdata", d, 8'h3C);

    // Address NACK -> STOP, err 1
    wlog.delete();
    sr_flags = 8'h80;
    do_req(1'b0, 7'h50, 8'h10, 8'h5A, e, d);
    exp_q = '{16'h03A0, 16'h0490, 16'h0440};
    chk_log("nack");
    chk("nack_err", e, 1);

    // Arbitration lost (with RxACK also set) -> err 2, no STOP
    wlog.delete();
    sr_flags = 8'hA0;
    do_req(1'b0, 7'h50, 8'h10, 8'h5A, e, d);
    exp_q = '{16'h03A0, 16'h0490};
    chk_log("al");
    chk("al_err", e, 2);

    // Ack timeout -> err 3, bus released after 16 cycles
    wlog.delete();
    sr_flags = 8'h00;
    ack_en = 1'b0;
    do_req(1'b0, 7'h21, 8'h01, 8'h0F, e, d);
    chk("to_err", e, 3);
    chk("to_stb_len", last_stb_len, 16);
    chk("to_stb", wbm_stb_o, 0);
    chk("to_cyc", wbm_cyc_o, 0);
    ack_en = 1'b1;
    wlog.delete();
    do_req(1'b0, 7'h21, 8'h01, 8'h0F, e, d);
    exp_q = '{16'h0342, 16'h0490, 16'h0301, 16'h0410, 16'h030F, 16'h0450};
    chk_log("after_to");
    chk("after_to_err", e, 0);

    // Reset during WAIT (SR poll in flight)
    wlog.delete();
    wait_ready("rst_req_ready");
    send_req(1'b0, 7'h50, 8'h10, 8'hA5);
    n_wait = 0;
    while (!(wlog.size() >= 2 && wbm_stb_o && !wbm_we_o) && n_wait < 500) begin
      @(negedge wb_clk_i);
      n_wait++;
    end
    chk("mid_poll_seen", (n_wait < 500), 1);
    rc = rsp_cnt;
    #2 arst_i = 1'b0;
    #1;
    chk("arst_stb", wbm_stb_o, 0);
    chk("arst_cyc", wbm_cyc_o, 0);
    chk("arst_adr", wbm_adr_o, 0);
    chk("arst_we", wbm_we_o, 0);
    wlog.delete();
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    arst_i = 1'b1;
    wait_ready("reinit_ready");
    chk("arst_no_rsp", rsp_cnt, rc);
    exp_q = '{16'h0063, 16'h0100, 16'h0280};
    chk_log("reinit");

    chk("cyc_eq_stb", cyc_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
